// File: rtl/cfg_rr_arb_if.sv
// Bus bundle for the cfg-bus round-robin arbiter.
// Requester side: per-requester address/write-data/strobes in, ack/read-data out.
// Target side: one shared address/write-data/strobe set out, ack/read-data in.
// Modports:
//   master - the arbiter's view (consumes requests, drives the target)
//   slave  - the environment's view (requesters plus target)
interface cfg_rr_arb_if #(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_wr;
  logic [NUM_REQ-1:0]    req_rd;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ*32-1:0] req_rdata;

  logic [31:0]           tgt_addr;
  logic [31:0]           tgt_wdata;
  logic                  tgt_wr;
  logic                  tgt_rd;
  logic                  tgt_ack;
  logic [31:0]           tgt_rdata;

  modport master (
    input  req_addr, req_wdata, req_wr, req_rd, tgt_ack, tgt_rdata,
    output req_ack, req_rdata, tgt_addr, tgt_wdata, tgt_wr, tgt_rd
  );

  modport slave (
    output req_addr, req_wdata, req_wr, req_rd, tgt_ack, tgt_rdata,
    input  req_ack, req_rdata, tgt_addr, tgt_wdata, tgt_wr, tgt_rd
  );

endinterface

// File: rtl/cfg_rr_arb.sv
// Round-robin arbiter that funnels NUM_REQ single-beat cfg-bus requesters onto one
// shared target port. Each requester pulse is parked in a pending slot; slots are
// served one at a time through IDLE -> ISSUE -> WAIT -> RESP.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   flr_assert   - function-level reset: abort the access, flush all slots
//   err_clr      - pulse clearing the sticky error flags
//   bus          - requester and target signals (cfg_rr_arb_if, master modport)
//   busy         - FSM not idle or any slot pending
//   timeout_err  - sticky: a target access timed out
//   drop_err     - sticky: a request pulse was discarded
module cfg_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flr_assert,
  input  logic         err_clr,
  cfg_rr_arb_if.master bus,
  output logic         busy,
  output logic         timeout_err,
  output logic         drop_err
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  // One extra bit so last_grant + k (k <= NUM_REQ) never overflows before the wrap.
  localparam int unsigned SW = GW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                   state_q, state_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [GW-1:0]            last_q, last_d;
  logic [NUM_REQ-1:0]       pend_q, pend_d;
  logic [NUM_REQ-1:0]       wr_q, wr_d;
  logic [NUM_REQ-1:0][31:0] addr_q, addr_d;
  logic [NUM_REQ-1:0][31:0] wdata_q, wdata_d;
  logic [31:0]              tgt_addr_q, tgt_addr_d;
  logic [31:0]              tgt_wdata_q, tgt_wdata_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [15:0]              cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;
  logic                     drop_q, drop_d;

  logic                     timeout_set;
  logic                     drop_set;
  logic [NUM_REQ-1:0]       slot_clr;
  logic                     rr_found;
  logic [GW-1:0]            rr_idx;
  logic [SW-1:0]            rr_sum;
  logic                     issue_live;
  logic                     resp_live;

  // Round-robin pick: first pending slot at or after last_grant + 1. The loop runs
  // from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_sum = {1'b0, last_q} + SW'(k);
      if (rr_sum >= SW'(NUM_REQ)) begin
        rr_sum = rr_sum - SW'(NUM_REQ);
      end
      if (pend_q[rr_sum[GW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_sum[GW-1:0];
      end
    end
  end

  // Access FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_wdata_d = tgt_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    timeout_set = 1'b0;
    slot_clr    = '0;

    case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d     = rr_idx;
          // Snapshot the slot so the target sees stable values until RESP, even if
          // the slot is refilled in the ack cycle.
          tgt_addr_d  = addr_q[rr_idx];
          tgt_wdata_d = wdata_q[rr_idx];
          state_d     = StIssue;
        end
      end
      StIssue: begin
        cnt_d = '0;
        if (bus.tgt_ack) begin
          rdata_d = wr_q[grant_q] ? 32'h0 : bus.tgt_rdata;
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.tgt_ack) begin
          rdata_d = wr_q[grant_q] ? 32'h0 : bus.tgt_rdata;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (TIMEOUT != 0 && cnt_d == 16'(TIMEOUT)) begin
            // Writes never return data, timed out or not.
            rdata_d     = wr_q[grant_q] ? 32'h0 : 32'hdead_beef;
            timeout_set = 1'b1;
            state_d     = StResp;
          end
        end
      end
      StResp: begin
        slot_clr[grant_q] = 1'b1;
        last_d            = grant_q;
        state_d           = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // FLR abandons the access without completing it, so last_grant is untouched.
    if (flr_assert) begin
      state_d = StIdle;
      cnt_d   = '0;
      last_d  = last_q;
    end
  end

  // Pending-slot capture. The completing slot is freed first so a pulse that lands
  // in its ack cycle is accepted instead of dropped.
  always_comb begin
    pend_d   = pend_q & ~slot_clr;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    drop_set = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_wr[i] || bus.req_rd[i]) begin
        // Simultaneous write and read: the write wins, the read is lost.
        if (bus.req_wr[i] && bus.req_rd[i]) begin
          drop_set = 1'b1;
        end
        if (pend_d[i]) begin
          drop_set = 1'b1;
        end else begin
          pend_d[i]  = 1'b1;
          wr_d[i]    = bus.req_wr[i];
          addr_d[i]  = bus.req_addr[32*i +: 32];
          wdata_d[i] = bus.req_wdata[32*i +: 32];
        end
      end
    end

    if (flr_assert) begin
      pend_d = '0;
    end

    // A same-cycle set beats err_clr.
    timeout_d = (timeout_q & ~err_clr) | timeout_set;
    drop_d    = (drop_q & ~err_clr) | drop_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      pend_q      <= '0;
      wr_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tgt_addr_q  <= '0;
      tgt_wdata_q <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_wdata_q <= tgt_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      drop_q      <= drop_d;
    end
  end

  // FLR masks strobes and acks in the very cycle it is seen.
  assign issue_live = (state_q == StIssue) && !flr_assert;
  assign resp_live  = (state_q == StResp) && !flr_assert;

  assign bus.tgt_addr  = tgt_addr_q;
  assign bus.tgt_wdata = tgt_wdata_q;
  assign bus.tgt_wr    = issue_live & wr_q[grant_q];
  assign bus.tgt_rd    = issue_live & ~wr_q[grant_q];

  always_comb begin
    bus.req_ack   = '0;
    bus.req_rdata = '0;
    if (resp_live) begin
      bus.req_ack[grant_q]                  = 1'b1;
      bus.req_rdata[32*int'(grant_q) +: 32] = rdata_q;
    end
  end

  assign busy        = (state_q != StIdle) || (|pend_q);
  assign timeout_err = timeout_q;
  assign drop_err    = drop_q;

endmodule

// File: tb/tb_cfg_rr_arb.sv
// Directed bench for cfg_rr_arb (NUM_REQ=4, TIMEOUT=4): a cycle table for
// round-robin, single read, drops and ack-cycle acceptance, then hand-written
// sequences for timeout, FLR abort and mid-access reset.
module tb_cfg_rr_arb;

  logic clk;
  logic rst;
  logic flr_assert;
  logic err_clr;
  logic busy;
  logic timeout_err;
  logic drop_err;

  cfg_rr_arb_if #(.NUM_REQ(4)) bif ();

  cfg_rr_arb #(
    .NUM_REQ(4),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flr_assert (flr_assert),
    .err_clr    (err_clr),
    .bus        (bif),
    .busy       (busy),
    .timeout_err(timeout_err),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wr;
    logic [3:0]  rd;
    int          tag;
    logic        clr;
    logic        ack;
    logic [31:0] rdin;
    logic [3:0]  xack;
    logic        xwr;
    logic        xrd;
    int          xg;
    int          xt;
    logic [31:0] xrdata;
    logic        xbusy;
    logic        xdrop;
  } vec_t;

  vec_t         vq[$];
  vec_t         v;
  logic [127:0] exp_rd;
  int           n_checks;
  int           n_fail;

  function automatic logic [31:0] addr_of(int i, int tag);
    return 32'h100 + 32'(tag) * 32'h1000 + 32'(i) * 32'h10;
  endfunction

  function automatic logic [31:0] wdata_of(int i, int tag);
    return 32'ha000_0000 + 32'(tag) * 32'h100 + 32'(i);
  endfunction

  function automatic vec_t mk(int wr, int rd, int tag, int clr, int ack, int rdin,
                              int xack, int xwr, int xrd, int xg, int xt, int xrdata,
                              int xbusy, int xdrop);
    vec_t r;
    r.wr = 4'(wr);       r.rd = 4'(rd);       r.tag = tag;
    r.clr = 1'(clr);     r.ack = 1'(ack);     r.rdin = 32'(rdin);
    r.xack = 4'(xack);   r.xwr = 1'(xwr);     r.xrd = 1'(xrd);
    r.xg = xg;           r.xt = xt;           r.xrdata = 32'(xrdata);
    r.xbusy = 1'(xbusy); r.xdrop = 1'(xdrop);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(int wr, int rd, int tag, int ack, int rdin, int flr, int clr);
    bif.req_wr  = 4'(wr);
    bif.req_rd  = 4'(rd);
    for (int i = 0; i < 4; i++) begin
      bif.req_addr[32*i +: 32]  = addr_of(i, tag);
      bif.req_wdata[32*i +: 32] = wdata_of(i, tag);
    end
    bif.tgt_ack   = 1'(ack);
    bif.tgt_rdata = 32'(rdin);
    flr_assert    = 1'(flr);
    err_clr       = 1'(clr);
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_in();

    // Round-robin burst from reset: 0,1,2,3 (tag 1).
    vq.push_back(mk(15, 0, 1, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 'h5555,  0, 1, 0, 0, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       1, 0, 0, 0, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 'h5555,  0, 1, 0, 1, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       2, 0, 0, 1, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 'h5555,  0, 1, 0, 2, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       4, 0, 0, 2, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 'h5555,  0, 1, 0, 3, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       8, 0, 0, 3, 1, 0, 1, 0));
    // Single write on requester 1 (tag 2) leaves last_grant = 1.
    vq.push_back(mk(2, 0, 2, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0,       0, 1, 0, 1, 2, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       2, 0, 0, 1, 2, 0, 1, 0));
    // Repeat burst (tag 3): 2,3,0,1.
    vq.push_back(mk(15, 0, 3, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0,       0, 1, 0, 2, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       4, 0, 0, 2, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0,       0, 1, 0, 3, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       8, 0, 0, 3, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0,       0, 1, 0, 0, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       1, 0, 0, 0, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0,       0, 1, 0, 1, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       2, 0, 0, 1, 3, 0, 1, 0));
    // Single read, addr 0x100, same-cycle target ack: req_ack at T+3.
    vq.push_back(mk(0, 1, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 'h1234,  0, 0, 1, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 'h1234, 1, 0));
    // Second read on busy slot 2 is dropped; original address survives.
    vq.push_back(mk(0, 4, 4, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 4, 5, 0, 0, 0,       0, 0, 1, 2, 4, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 'hcafe0002, 0, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       4, 0, 0, 2, 4, 'hcafe0002, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0,       0, 0, 0, 0, 0, 0, 0, 1));
    // Write and read together on requester 3: write kept, drop flagged, rdata 0.
    vq.push_back(mk(8, 8, 6, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 'h6666,  0, 1, 0, 3, 6, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       8, 0, 0, 3, 6, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0,       0, 0, 0, 0, 0, 0, 0, 1));
    // New pulse in the ack cycle is accepted without a drop.
    vq.push_back(mk(0, 2, 7, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 'h7777,  0, 0, 1, 1, 7, 0, 1, 0));
    vq.push_back(mk(0, 2, 8, 0, 0, 0,       2, 0, 0, 1, 7, 'h7777, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 'h8888,  0, 0, 1, 1, 8, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       2, 0, 0, 1, 8, 'h8888, 1, 0));
    // Stray target ack in IDLE does nothing.
    vq.push_back(mk(0, 0, 0, 0, 1, 'h9999,  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state.
    step();
    step();
    chk("rst req_ack", 128'(bif.req_ack), 128'(4'h0));
    chk("rst req_rdata", bif.req_rdata, 128'h0);
    chk("rst tgt_addr", 128'(bif.tgt_addr), 128'(32'h0));
    chk("rst tgt_wr", 128'(bif.tgt_wr), 128'(1'b0));
    chk("rst tgt_rd", 128'(bif.tgt_rd), 128'(1'b0));
    chk("rst busy", 128'(busy), 128'(1'b0));
    chk("rst errs", 128'({timeout_err, drop_err}), 128'(2'b00));
    rst = 1'b0;

    foreach (vq[n]) begin
      v = vq[n];
      drive(int'(v.wr), int'(v.rd), v.tag, int'(v.ack), int'(v.rdin), 0, int'(v.clr));
      #1;
      chk($sformatf("vec%0d req_ack", n), 128'(bif.req_ack), 128'(v.xack));
      chk($sformatf("vec%0d tgt_wr", n), 128'(bif.tgt_wr), 128'(v.xwr));
      chk($sformatf("vec%0d tgt_rd", n), 128'(bif.tgt_rd), 128'(v.xrd));
      chk($sformatf("vec%0d busy", n), 128'(busy), 128'(v.xbusy));
      chk($sformatf("vec%0d drop_err", n), 128'(drop_err), 128'(v.xdrop));
      chk($sformatf("vec%0d timeout_err", n), 128'(timeout_err), 128'(1'b0));
      if (v.xwr || v.xrd || (v.xack != 4'h0)) begin
        chk($sformatf("vec%0d tgt_addr", n), 128'(bif.tgt_addr), 128'(addr_of(v.xg, v.xt)));
        chk($sformatf("vec%0d tgt_wdata", n), 128'(bif.tgt_wdata),
            128'(wdata_of(v.xg, v.xt)));
      end
      exp_rd = '0;
      for (int i = 0; i < 4; i++) begin
        if (v.xack[i]) exp_rd[32*i +: 32] = v.xrdata;
      end
      chk($sformatf("vec%0d req_rdata", n), bif.req_rdata, exp_rd);
      step();
    end

    // Timeout: target never answers, RESP after 4 WAIT cycles.
    drive(0, 1, 9, 0, 0, 0, 0); #1; step();
    idle_in(); #1; chk("tmo busy", 128'(busy), 128'(1'b1)); step();
    idle_in(); #1;
    chk("tmo tgt_rd", 128'(bif.tgt_rd), 128'(1'b1));
    chk("tmo tgt_addr", 128'(bif.tgt_addr), 128'(addr_of(0, 9)));
    step();
    for (int k = 0; k < 4; k++) begin
      idle_in(); #1;
      chk($sformatf("tmo wait%0d req_ack", k), 128'(bif.req_ack), 128'(4'h0));
      chk($sformatf("tmo wait%0d tgt_rd", k), 128'(bif.tgt_rd), 128'(1'b0));
      step();
    end
    idle_in(); #1;
    chk("tmo req_ack", 128'(bif.req_ack), 128'(4'h1));
    chk("tmo req_rdata", bif.req_rdata, 128'(32'hdead_beef));
    chk("tmo timeout_err", 128'(timeout_err), 128'(1'b1));
    step();
    drive(0, 0, 0, 0, 0, 0, 1); #1;
    chk("tmo clr cycle", 128'(timeout_err), 128'(1'b1));
    step();
    idle_in(); #1;
    chk("tmo cleared", 128'(timeout_err), 128'(1'b0));
    chk("tmo idle busy", 128'(busy), 128'(1'b0));
    step();

    // FLR in WAIT: back to IDLE, no ack, late target ack ignored.
    drive(0, 4, 10, 0, 0, 0, 0); #1; step();
    idle_in(); #1; step();
    idle_in(); #1; chk("flr issue tgt_rd", 128'(bif.tgt_rd), 128'(1'b1)); step();
    drive(0, 0, 0, 0, 0, 1, 0); #1;
    chk("flr wait busy", 128'(busy), 128'(1'b1));
    chk("flr wait req_ack", 128'(bif.req_ack), 128'(4'h0));
    step();
    drive(0, 0, 0, 1, 'h1111, 0, 0); #1;
    chk("flr idle busy", 128'(busy), 128'(1'b0));
    chk("flr idle req_ack", 128'(bif.req_ack), 128'(4'h0));
    step();
    idle_in(); #1;
    chk("flr late req_ack", 128'(bif.req_ack), 128'(4'h0));
    chk("flr late strobes", 128'({bif.tgt_wr, bif.tgt_rd}), 128'(2'b00));
    chk("flr late busy", 128'(busy), 128'(1'b0));
    step();

    // Reset in ISSUE (with drop_err set): everything to 0 at once, nothing after.
    drive(8, 8, 11, 0, 0, 0, 0); #1; step();
    idle_in(); #1; chk("rstm drop_err", 128'(drop_err), 128'(1'b1)); step();
    idle_in(); #1; chk("rstm tgt_wr", 128'(bif.tgt_wr), 128'(1'b1));
    #1 rst = 1'b1;
    #1;
    chk("rstm req_ack", 128'(bif.req_ack), 128'(4'h0));
    chk("rstm req_rdata", bif.req_rdata, 128'h0);
    chk("rstm tgt_addr", 128'(bif.tgt_addr), 128'(32'h0));
    chk("rstm tgt_wdata", 128'(bif.tgt_wdata), 128'(32'h0));
    chk("rstm strobes", 128'({bif.tgt_wr, bif.tgt_rd}), 128'(2'b00));
    chk("rstm busy", 128'(busy), 128'(1'b0));
    chk("rstm errs", 128'({timeout_err, drop_err}), 128'(2'b00));
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      idle_in(); #1;
      chk($sformatf("rstm after%0d strobes", k), 128'({bif.tgt_wr, bif.tgt_rd}), 128'(2'b00));
      chk($sformatf("rstm after%0d req_ack", k), 128'(bif.req_ack), 128'(4'h0));
      step();
    end

    // last_grant back to 3 after reset: requesters 0 and 3 -> 0 first.
    drive(9, 0, 12, 0, 0, 0, 0); #1; step();
    idle_in(); #1; step();
    drive(0, 0, 0, 1, 0, 0, 0); #1;
    chk("post-rst first tgt_addr", 128'(bif.tgt_addr), 128'(addr_of(0, 12)));
    step();
    idle_in(); #1; chk("post-rst first ack", 128'(bif.req_ack), 128'(4'h1)); step();
    idle_in(); #1; step();
    drive(0, 0, 0, 1, 0, 0, 0); #1;
    chk("post-rst second tgt_addr", 128'(bif.tgt_addr), 128'(addr_of(3, 12)));
    step();
    idle_in(); #1; chk("post-rst second ack", 128'(bif.req_ack), 128'(4'h8)); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_rr_arb.md
CFG_RR_ARB -- requirements
Module: cfg_rr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4; number of cfg-bus requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255; WAIT-cycle limit before forced completion; 0 disables timeout.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have port flr_assert  in  1  function-level reset; aborts the in-flight access.
REQ-006 SHALL have port err_clr  in  1  one-cycle pulse; clears sticky error flags.
REQ-007 SHALL have port req_addr  in  NUM_REQ*32  per-requester address; slice i = bits [32i+31:32i].
REQ-008 SHALL have port req_wdata  in  NUM_REQ*32  per-requester write data.
REQ-009 SHALL have port req_wr  in  NUM_REQ  one-cycle write pulse per requester.
REQ-010 SHALL have port req_rd  in  NUM_REQ  one-cycle read pulse per requester.
REQ-011 SHALL have port req_ack  out  NUM_REQ  one-cycle completion pulse per requester.
REQ-012 SHALL have port req_rdata  out  NUM_REQ*32  read data, valid only with the matching req_ack bit.
REQ-013 SHALL have port tgt_addr  out  32  shared target address.
REQ-014 SHALL have port tgt_wdata  out  32  shared target write data.
REQ-015 SHALL have port tgt_wr  out  1  one-cycle target write pulse.
REQ-016 SHALL have port tgt_rd  out  1  one-cycle target read pulse.
REQ-017 SHALL have port tgt_ack  in  1  target completion; may be asserted in the same cycle as tgt_wr/tgt_rd.
REQ-018 SHALL have port tgt_rdata  in  32  target read data, valid with tgt_ack.
REQ-019 SHALL have port busy  out  1  high whenever state != IDLE or any request is pending.
REQ-020 SHALL have port timeout_err  out  1  sticky; set on any timeout.
REQ-021 SHALL have port drop_err  out  1  sticky; set when a request pulse is dropped.

Function
REQ-022 SHALL latch each req_wr/req_rd pulse into a per-requester pending slot (type, addr, wdata) on the next edge.
REQ-023 SHALL give write priority if req_wr[i] and req_rd[i] pulse together: record a write, discard the read, set drop_err.
REQ-024 SHALL ignore a pulse on a requester whose slot is already pending, keep the original request, and set drop_err.
REQ-025 SHALL accept and latch a new pulse on requester i that arrives in the same cycle as req_ack[i]; this SHALL NOT set drop_err.
REQ-026 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-027 SHALL, in IDLE with any slot pending, grant round-robin starting at (last_grant+1) mod NUM_REQ, then enter ISSUE; last_grant resets to NUM_REQ-1.
REQ-028 SHALL, in ISSUE, drive tgt_addr/tgt_wdata from the granted slot, assert tgt_wr or tgt_rd for exactly this cycle, and then enter WAIT.
REQ-029 SHALL sample tgt_ack in ISSUE and WAIT; when it is high, capture tgt_rdata and enter RESP.
REQ-030 SHALL count WAIT cycles with a 16-bit counter; when TIMEOUT != 0 and the count reaches TIMEOUT without an ack, SHALL capture 32'hdead_beef, set timeout_err and enter RESP.
REQ-031 SHALL, in RESP, pulse req_ack[grant] for one cycle with req_rdata[grant] = captured data, clear that slot, update last_grant and return to IDLE.
REQ-032 SHALL drive req_rdata slices of non-acked requesters to 0 and return rdata 32'h0 for writes.
REQ-033 SHALL hold tgt_addr/tgt_wdata stable from ISSUE through RESP.
REQ-034 SHALL achieve minimum latency from req pulse (cycle T) to req_ack of T+3 (slot at T+1, ISSUE at T+2 with same-cycle tgt_ack, RESP at T+3).
REQ-035 SHALL, on flr_assert in any state, go to IDLE next cycle, clear all slots, suppress req_ack and tgt pulses, and retain error flags.
REQ-036 SHALL ignore a tgt_ack arriving in IDLE or RESP.
REQ-037 SHALL give err_clr priority below a same-cycle error set (set wins).

Reset
REQ-038 SHALL, on rst, drive all outputs to 0, clear slots, counter and errors, set state to IDLE and last_grant to NUM_REQ-1.
REQ-039 SHALL, when rst asserts mid-access, drop the access with no ack and no further tgt pulse after deassertion.

Verification
REQ-040 SHALL test a single read: req_rd[0] at T, addr 0x100, tgt_ack with tgt_rdata 0x1234 in ISSUE -> req_ack[0] at T+3, req_rdata[0]=0x1234.
REQ-041 SHALL test round-robin: req_wr[0..3] pulsed together -> tgt_wr serviced in order 0,1,2,3; a repeat burst after grant 1 -> order 2,3,0,1.
REQ-042 SHALL test timeout: TIMEOUT=4, target never acks -> req_ack after 4 WAIT cycles, rdata 0xdeadbeef, timeout_err=1; err_clr -> 0.
REQ-043 SHALL test drops: a second req_rd[2] while slot 2 is pending -> drop_err=1, one ack only, original addr on tgt_addr.
REQ-044 SHALL test abort: flr_assert in WAIT -> IDLE next cycle, no req_ack, busy=0; a later tgt_ack is ignored.
REQ-045 SHALL test reset: rst asserted in ISSUE -> all outputs 0 immediately, no further tgt_wr/tgt_rd after release.
